// File: rtl/tt_um_nasser_hadi_uart_tx.sv
// UART transmitter (8N1 / 8E1) on the TinyTapeout pin interface, with busy/done status and a 5-bit sent counter.
// Latency: txd falls on the 3rd rising clk edge after the request rises (2-flop sync + edge detect + launch).
// Backpressure: none; a request edge arriving while a frame is in flight is dropped, not queued.
module tt_um_nasser_hadi_uart_tx #(
  parameter int DIV_BASE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Wide enough to hold DIV_BASE << 3, the slowest baud selection.
  localparam int DIV_W = $clog2(DIV_BASE * 8) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } state_t;

  state_t           state;
  logic             s1, s2, prev;
  logic             req_edge;
  logic [7:0]       shreg;
  logic             par_en;
  logic             par_bit;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] tmr;
  logic [2:0]       bit_idx;
  logic             bit_end;
  logic             txd;
  logic             busy;
  logic             done;
  logic [4:0]       count;
  logic             unused_bits;

  // ena and the spare uio inputs carry no function in this design.
  assign unused_bits = ^{ena, uio_in[7:4]};

  assign req_edge = s2 & ~prev;
  assign bit_end  = (tmr == div - DIV_W'(1));

  // Synchronise the asynchronous request level and keep one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= uio_in[0];
      s2   <= s1;
      prev <= s2;
    end
  end

  // Frame sequencer: every output bit, busy and done are registered together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= 8'd0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      div     <= DIV_W'(DIV_BASE);
      tmr     <= '0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          tmr  <= '0;
          if (req_edge) begin
            // Everything the frame depends on is captured here so later input changes cannot disturb it.
            shreg   <= ui_in;
            par_en  <= uio_in[1];
            par_bit <= ^ui_in;
            div     <= DIV_W'(DIV_BASE) << uio_in[3:2];
            state   <= START;
            busy    <= 1'b1;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            tmr     <= '0;
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
          end else begin
            tmr <= tmr + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              if (par_en) begin
                state <= PARITY;
                txd   <= par_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            tmr <= tmr + DIV_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            tmr   <= '0;
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            tmr <= tmr + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            tmr   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= count + 5'd1;
            txd   <= 1'b1;
          end else begin
            tmr <= tmr + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
          tmr   <= '0;
        end
      endcase
    end
  end

  assign uo_out  = {count, done, busy, txd};
  assign uio_out = {state, txd, 4'b0000};
  assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_nasser_hadi_uart_tx.sv
// Bench for the UART transmitter: expected frames are built from the byte, parity flag and baud divisor.
// Inputs are driven and outputs sampled on the falling clock edge.
// The design has no input backpressure; the bench only waits for txd/done with bounded loops.
module tb_tt_um_nasser_hadi_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int cnt_model = 0;

  tt_um_nasser_hadi_uart_tx #(.DIV_BASE(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks it bit by bit against the model.
  // pre_req: the request edge was already raised by the previous frame (back-to-back).
  // mid_req: disturb ui_in / parity / baud and pulse the request during the frame.
  // early_next: raise the next request so its edge lands in this frame's done cycle.
  task automatic do_frame(input logic [7:0] data, input logic par, input logic [1:0] baud,
                          input bit pre_req, input bit mid_req, input bit early_next);
    int   div;
    int   nb;
    int   waitc;
    logic exp_bits[11];
    bit   busy_ok;

    div = 16 << baud;
    nb  = par ? 11 : 10;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = data[i];
    if (par) begin
      exp_bits[9]  = ($countones(data) % 2) == 1;
      exp_bits[10] = 1'b1;
    end else begin
      exp_bits[9]  = 1'b1;
      exp_bits[10] = 1'b1;
    end

    ui_in      = data;
    uio_in[1]  = par;
    uio_in[3:2] = baud;

    if (!pre_req) begin
      uio_in[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("txd_before_launch", uo_out[0], 1'b1);
      @(negedge clk);
      chk("txd_fall_3rd_edge", uo_out[0], 1'b0);
    end else begin
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
      end while (uo_out[0] !== 1'b0 && waitc < 10);
      chk("b2b_start_gap", waitc, 1);
    end
    start_cyc = cyc;

    busy_ok = 1'b1;
    for (int t = 0; t <= nb * div; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 4) uio_in[0] = 1'b0;
      if (mid_req && t == 40) begin
        ui_in       = 8'hFF;
        uio_in[0]   = 1'b1;
        uio_in[1]   = ~par;
        uio_in[3:2] = baud + 2'd1;
      end
      if (mid_req && t == 48) uio_in[0] = 1'b0;
      if (early_next && t == nb * div - 2) uio_in[0] = 1'b1;
      if (t < nb * div) begin
        if (uo_out[1] !== 1'b1 || uo_out[2] !== 1'b0) busy_ok = 1'b0;
        if (t % div == div / 2) chk($sformatf("bit%0d_d%0h", t / div, data), uo_out[0], exp_bits[t/div]);
      end
    end
    chk("busy_whole_frame", busy_ok, 1'b1);
    chk("done_at_frame_end", uo_out[2], 1'b1);
    chk("idle_after_frame", {uo_out[1], uo_out[0]}, 2'b01);
    cnt_model = (cnt_model + 1) % 32;
    chk("counter", uo_out[7:3], cnt_model[4:0]);
    if (!early_next) begin
      @(negedge clk);
      chk("done_one_cycle", uo_out[2], 1'b0);
    end
  endtask

  initial begin
    bit          quiet;
    int          prev_start;
    logic [7:0]  d;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_uo_out", uo_out, 8'h01);
    chk("reset_uio_oe", uio_oe, 8'hF0);
    chk("reset_uio_out", uio_out, 8'h10);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5, baud 0, no parity
    do_frame(8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // 0x07, parity on, baud 2: 11 bits of 64 clocks
    do_frame(8'h07, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // Mid-frame request with changed byte/settings: original frame only, nothing follows
    do_frame(8'h3B, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (uo_out[1] !== 1'b0 || uo_out[0] !== 1'b1 || uo_out[2] !== 1'b0) quiet = 1'b0;
    end
    chk("no_second_frame", quiet, 1'b1);
    chk("counter_single_inc", uo_out[7:3], cnt_model[4:0]);

    // Randomized frames
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      do_frame(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
    end

    // Reset during DATA bit 3
    ui_in       = 8'h3C;
    uio_in[3:1] = 3'b000;
    uio_in[0]   = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_start", uo_out[0], 1'b0);
    for (int t = 1; t <= 69; t++) begin
      @(negedge clk);
      if (t == 4) uio_in[0] = 1'b0;
    end
    chk("abort_in_data", uio_out[7:5], 3'b010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd", uo_out[0], 1'b1);
    chk("abort_busy", uo_out[1], 1'b0);
    chk("abort_counter", uo_out[7:3], 5'd0);
    chk("abort_no_done", uo_out[2], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_model = 0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (uo_out[2] !== 1'b0 || uo_out[1] !== 1'b0) quiet = 1'b0;
    end
    chk("abort_stays_idle", quiet, 1'b1);

    // 33 frames back to back at baud 0
    prev_start = 0;
    for (int i = 0; i < 33; i++) begin
      d = 8'($urandom);
      do_frame(d, 1'b0, 2'd0, i != 0, 1'b0, i != 32);
      if (i > 0) chk("start_spacing_ge_161", (start_cyc - prev_start) >= 161, 1'b1);
      prev_start = start_cyc;
    end
    chk("counter_after_wrap", uo_out[7:3], 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
